// File: rtl/config_pkg.sv
// ----------------------------------------------------------------------------
// config_pkg
//   Shared definitions for the configuration bus. It holds the loader FSM
//   state encoding, the default bitstream header magic and the field
//   positions inside config_addr. The tile address matchers decode with the
//   same field positions.
//
//   config_addr layout: {8'b0, config_id[7:0], tile_id[15:0]}
//   header word layout: {magic[15:0], write_count[15:0]}
// ----------------------------------------------------------------------------
package config_pkg;

   // Loader FSM states. The encoding is also exported on the debug port.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_ADDR  = 3'd2,
      S_DATA  = 3'd3,
      S_ISSUE = 3'd4,
      S_WAIT  = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } cfg_state_t;

   // Header magic expected in bits [31:16] of the first bitstream word.
   localparam logic [15:0] DEFAULT_MAGIC = 16'hC0F6;

   // Header field positions.
   localparam int HDR_MAGIC_MSB = 31;
   localparam int HDR_MAGIC_LSB = 16;
   localparam int HDR_COUNT_MSB = 15;
   localparam int HDR_COUNT_LSB = 0;

   // config_addr field positions, shared with the tile address matchers.
   localparam int TILE_ID_MSB   = 15;
   localparam int TILE_ID_LSB   = 0;
   localparam int CONFIG_ID_MSB = 23;
   localparam int CONFIG_ID_LSB = 16;

   // Build a config_addr word from its fields. Bits [31:24] are always zero.
   function automatic logic [31:0] make_config_addr(input logic [7:0]  config_id,
                                                    input logic [15:0] tile_id);
      logic [31:0] a;
      a = '0;
      a[CONFIG_ID_MSB:CONFIG_ID_LSB] = config_id;
      a[TILE_ID_MSB:TILE_ID_LSB]     = tile_id;
      return a;
   endfunction

   // True in the states where the loader owns the bitstream and bus.
   function automatic logic state_is_busy(input cfg_state_t s);
      return (s == S_HDR) || (s == S_ADDR) || (s == S_DATA) ||
             (s == S_ISSUE) || (s == S_WAIT);
   endfunction

   // True in the states that accept a bitstream word.
   function automatic logic state_is_receive(input cfg_state_t s);
      return (s == S_HDR) || (s == S_ADDR) || (s == S_DATA);
   endfunction

endpackage : config_pkg

// File: rtl/config_loader.sv
// ----------------------------------------------------------------------------
// config_loader
//   Bitstream-driven configuration master at the tile array root. A load
//   starts with a header word {MAGIC, N}. N (address, data) word pairs
//   follow. Each pair is replayed onto config_addr/config_data with a
//   one-cycle config_we strobe. After each strobe the loader waits GAP idle
//   cycles.
//
//   Handshake: a bitstream word is consumed on a rising clock edge where
//   bs_valid and bs_ready are both high. bs_ready is a registered decode of
//   the FSM state and never depends on bs_valid. A word offered while
//   bs_ready is low is not consumed, and the host must keep offering it.
//
// Parameters
//   MAGIC        required header bits [31:16]
//   GAP          idle cycles after each write strobe, 0..15
//
// Ports
//   clk          clock
//   reset        asynchronous active-low reset
//   start        one-cycle pulse that begins a load when not busy
//   bs_data      bitstream word
//   bs_valid     bs_data is valid
//   bs_ready     loader accepts bs_data this cycle
//   config_addr  {8'b0, config_id, tile_id}, held between strobes
//   config_data  write payload, held between strobes
//   config_we    one-cycle write strobe
//   busy         a load is in progress
//   done         last load completed cleanly (level)
//   error        last load aborted on a bad header (level)
//   writes_done  strobes issued in the current or last load
//   fsm_state    debug view of the FSM state
// ----------------------------------------------------------------------------
module config_loader
   import config_pkg::*;
#(
   parameter logic [15:0] MAGIC = DEFAULT_MAGIC,
   parameter int unsigned GAP   = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] bs_data,
   input  logic        bs_valid,
   output logic        bs_ready,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        config_we,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] writes_done,
   output cfg_state_t  fsm_state
);

   // The gap counter is loaded with GAP-1 on leaving ISSUE. WAIT therefore
   // lasts exactly GAP cycles and exits when the counter reads zero.
   localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
   localparam bit         HAS_GAP  = (GAP != 0);

   cfg_state_t  state;
   cfg_state_t  next_state;

   logic        ready_q;
   logic [15:0] count_n;      // N latched from the header
   logic [15:0] writes_cnt;
   logic [3:0]  gap_cnt;
   logic        last_write;   // the WAIT in progress follows the final write
   logic [31:0] addr_q;
   logic [31:0] data_q;

   logic        hs;
   logic        header_ok;
   logic        header_empty;
   logic        final_write;
   logic        start_ok;

   assign hs           = bs_valid & ready_q;
   assign header_ok    = (bs_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == MAGIC);
   assign header_empty = (bs_data[HDR_COUNT_MSB:HDR_COUNT_LSB] == 16'd0);
   // writes_cnt never exceeds N, so the increment cannot wrap here.
   assign final_write  = ((writes_cnt + 16'd1) == count_n);
   // start counts only in the resting states. A start during a load, or
   // during the final ISSUE, has no effect.
   assign start_ok     = start & ((state == S_IDLE) || (state == S_DONE) ||
                                  (state == S_ERR));

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) next_state = S_HDR;
         end
         S_HDR: begin
            if (hs) begin
               if (!header_ok)        next_state = S_ERR;
               else if (header_empty) next_state = S_DONE;
               else                   next_state = S_ADDR;
            end
         end
         S_ADDR: begin
            if (hs) next_state = S_DATA;
         end
         S_DATA: begin
            if (hs) next_state = S_ISSUE;
         end
         S_ISSUE: begin
            if (final_write) next_state = HAS_GAP ? S_WAIT : S_DONE;
            else             next_state = HAS_GAP ? S_WAIT : S_ADDR;
         end
         S_WAIT: begin
            if (gap_cnt == 4'd0) next_state = last_write ? S_DONE : S_ADDR;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State register. bs_ready is registered from the next state, so it is
   // high exactly while the FSM sits in a receive state.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         ready_q <= 1'b0;
      end else begin
         state   <= next_state;
         ready_q <= state_is_receive(next_state);
      end
   end

   // ------------------------------------------------------------------------
   // Count, gap counter and bus registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_n    <= 16'd0;
         writes_cnt <= 16'd0;
         gap_cnt    <= 4'd0;
         last_write <= 1'b0;
         addr_q     <= 32'd0;
         data_q     <= 32'd0;
      end else begin
         if (start_ok) begin
            writes_cnt <= 16'd0;
            last_write <= 1'b0;
         end

         if ((state == S_HDR) && hs && header_ok) begin
            count_n <= bs_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
         end

         if ((state == S_ADDR) && hs) begin
            addr_q <= bs_data;
         end

         if ((state == S_DATA) && hs) begin
            data_q <= bs_data;
         end

         if (state == S_ISSUE) begin
            writes_cnt <= writes_cnt + 16'd1;
            last_write <= final_write;
            gap_cnt    <= GAP_LAST;
         end else if ((state == S_WAIT) && (gap_cnt != 4'd0)) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: all are decodes of registered state, so reset clears them at
   // once and a strobe in flight is dropped.
   // ------------------------------------------------------------------------
   assign bs_ready    = ready_q;
   assign config_addr = addr_q;
   assign config_data = data_q;
   assign config_we   = (state == S_ISSUE);
   assign busy        = state_is_busy(state);
   assign done        = (state == S_DONE);
   assign error       = (state == S_ERR);
   assign writes_done = writes_cnt;
   assign fsm_state   = state;

endmodule : config_loader

// File: tb/tb_config_loader.sv
// ----------------------------------------------------------------------------
// tb_config_loader
//   Two loaders share the clock and reset: inst 0 with GAP=0 and inst 1 with
//   GAP=2. A table of load vectors is applied in a loop, and hand-written
//   sequences cover reset during a load. A negedge monitor checks every
//   strobe against an expected queue.
// ----------------------------------------------------------------------------
module tb_config_loader;
   import config_pkg::*;

   localparam int NI = 2;

   logic        clk;
   logic        rst;
   logic        start       [NI];
   logic [31:0] bs_data     [NI];
   logic        bs_valid    [NI];
   logic        bs_ready    [NI];
   logic [31:0] config_addr [NI];
   logic [31:0] config_data [NI];
   logic        config_we   [NI];
   logic        busy        [NI];
   logic        done        [NI];
   logic        error       [NI];
   logic [15:0] writes_done [NI];
   cfg_state_t  fsm_state   [NI];

   // ---------------- DUTs ----------------
   config_loader #(.MAGIC(16'hC0F6), .GAP(0)) dut0 (
      .clk(clk), .reset(rst), .start(start[0]), .bs_data(bs_data[0]),
      .bs_valid(bs_valid[0]), .bs_ready(bs_ready[0]),
      .config_addr(config_addr[0]), .config_data(config_data[0]),
      .config_we(config_we[0]), .busy(busy[0]), .done(done[0]),
      .error(error[0]), .writes_done(writes_done[0]), .fsm_state(fsm_state[0])
   );

   config_loader #(.MAGIC(16'hC0F6), .GAP(2)) dut1 (
      .clk(clk), .reset(rst), .start(start[1]), .bs_data(bs_data[1]),
      .bs_valid(bs_valid[1]), .bs_ready(bs_ready[1]),
      .config_addr(config_addr[1]), .config_data(config_data[1]),
      .config_we(config_we[1]), .busy(busy[1]), .done(done[1]),
      .error(error[1]), .writes_done(writes_done[1]), .fsm_state(fsm_state[1])
   );

   function automatic int gap_of(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   // ---------------- clock / reset ----------------
   int cyc = 0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_q0[$];
   logic [63:0] exp_q1[$];

   int strobe_cnt  [NI];
   int last_strobe [NI];
   int hs_cyc      [NI];
   bit tog         [NI];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int i, input logic [63:0] v);
      if (i == 0) exp_q0.push_back(v);
      else        exp_q1.push_back(v);
   endtask

   function automatic int exp_size(input int i);
      return (i == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   task automatic mon_inst(input int i);
      logic [63:0] e;
      if (bs_valid[i] && bs_ready[i] && fsm_state[i] == S_DATA) hs_cyc[i] = cyc + 1;
      if (config_we[i]) begin
         strobe_cnt[i]++;
         if (exp_size(i) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_strobe inst%0d: got addr %h data %h expected no strobe",
                     i, config_addr[i], config_data[i]);
         end else begin
            if (i == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check($sformatf("strobe_pair_inst%0d", i), {config_addr[i], config_data[i]}, e);
         end
         check($sformatf("write_latency_inst%0d", i), 64'(cyc), 64'(hs_cyc[i]));
         if (gap_of(i) > 0 && last_strobe[i] >= 0)
            check($sformatf("gap_idle_ge2_inst%0d", i), 64'((cyc - last_strobe[i] - 1) >= 2), 64'd1);
         last_strobe[i] = cyc;
      end
   endtask

   always @(negedge clk) begin
      #1;
      for (int i = 0; i < NI; i++) mon_inst(i);
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input int i);
      @(negedge clk);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      check($sformatf("start_latency_ready_inst%0d", i), 64'(bs_ready[i]), 64'd1);
      check($sformatf("start_clears_flags_inst%0d", i),
            {done[i], error[i], writes_done[i]}, 64'd0);
   endtask

   // Offers one word and returns at the negedge before the accepting edge.
   // hs is the cycle number of that accepting edge.
   task automatic send_word(input int i, input logic [31:0] w, input bit toggle, output int hs);
      bit accepted;
      int budget;
      accepted = 1'b0;
      budget   = 100;
      hs       = -1;
      while (!accepted && budget > 0) begin
         @(negedge clk);
         bs_data[i] = w;
         if (toggle) begin
            tog[i]      = ~tog[i];
            bs_valid[i] = tog[i];
         end else begin
            bs_valid[i] = 1'b1;
         end
         if (bs_valid[i] && bs_ready[i]) begin
            accepted = 1'b1;
            hs       = cyc + 1;
         end
         budget--;
      end
      if (!accepted) begin
         n_checks++;
         n_fail++;
         $display("FAIL word_accept_timeout inst%0d: word %h not accepted within 100 cycles", i, w);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int              inst;
      logic [31:0]     hdr;
      int              npairs;
      bit              toggle;
      bit              poke_start;
      logic [2:0][31:0] addr;
      logic [2:0][31:0] data;
      logic            exp_done;
      logic            exp_error;
      logic [15:0]     exp_wd;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs[NV];

   function automatic vec_t mk(input int inst, input logic [31:0] hdr, input int np,
                               input bit tg, input bit pk, input logic ed,
                               input logic ee, input logic [15:0] ewd, input int seed);
      vec_t v;
      v.inst       = inst;
      v.hdr        = hdr;
      v.npairs     = np;
      v.toggle     = tg;
      v.poke_start = pk;
      v.exp_done   = ed;
      v.exp_error  = ee;
      v.exp_wd     = ewd;
      for (int k = 0; k < 3; k++) begin
         v.addr[k] = make_config_addr(8'(seed * 4 + k + 1), 16'(seed * 256 + k * 17 + 3));
         v.data[k] = 32'h5A00_0000 | 32'(seed * 4096 + k * 257 + 11);
      end
      return v;
   endfunction

   task automatic run_load(input vec_t v, input string tag);
      int i, hs_hdr, hs_tmp, s0, budget;
      bit ended;
      i = v.inst;
      s0 = strobe_cnt[i];
      last_strobe[i] = -1;
      tog[i] = 1'b0;
      for (int k = 0; k < v.npairs; k++) push_exp(i, {v.addr[k], v.data[k]});

      pulse_start(i);
      send_word(i, v.hdr, v.toggle, hs_hdr);

      if (v.poke_start) begin
         @(negedge clk);
         bs_valid[i] = 1'b0;
         start[i]    = 1'b1;
         @(negedge clk);
         start[i]    = 1'b0;
         check({tag, "_start_busy_state"}, 64'(fsm_state[i]), 64'(S_ADDR));
         check({tag, "_start_busy_flags"}, {busy[i], bs_ready[i], writes_done[i]},
               {46'd0, 1'b1, 1'b1, 16'd0});
      end

      for (int k = 0; k < v.npairs; k++) begin
         send_word(i, v.addr[k], v.toggle, hs_tmp);
         send_word(i, v.data[k], v.toggle, hs_tmp);
      end
      @(negedge clk);
      bs_valid[i] = 1'b0;

      ended  = 1'b0;
      budget = 200;
      while (!ended && budget > 0) begin
         if (done[i] || error[i]) ended = 1'b1;
         else begin
            @(negedge clk);
            budget--;
         end
      end
      if (!ended) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_end_timeout: done/error not seen within 200 cycles", tag);
      end

      if (v.npairs == 0)
         check({tag, "_end_timing"}, 64'(cyc), 64'(hs_hdr));
      else
         check({tag, "_end_timing"}, 64'(cyc), 64'(last_strobe[i] + 1 + gap_of(i)));

      check({tag, "_done"},        64'(done[i]),        64'(v.exp_done));
      check({tag, "_error"},       64'(error[i]),       64'(v.exp_error));
      check({tag, "_writes_done"}, 64'(writes_done[i]), 64'(v.exp_wd));
      check({tag, "_idle_flags"},  {busy[i], bs_ready[i], config_we[i]}, 64'd0);
      check({tag, "_strobe_count"}, 64'(strobe_cnt[i] - s0), 64'(v.exp_wd));
      check({tag, "_queue_empty"}, 64'(exp_size(i)), 64'd0);
   endtask

   // ---------------- main test ----------------
   initial begin
      vec_t v;
      int   hs_tmp;

      for (int i = 0; i < NI; i++) begin
         start[i]       = 1'b0;
         bs_data[i]     = 32'd0;
         bs_valid[i]    = 1'b0;
         strobe_cnt[i]  = 0;
         last_strobe[i] = -1;
         hs_cyc[i]      = -1;
         tog[i]         = 1'b0;
      end

      // Vector table: inst, header, pairs, toggle, poke start, done, error, writes.
      vecs[0] = mk(0, 32'hC0F6_0001, 1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 0);
      vecs[0].addr[0] = 32'h0001_0003;
      vecs[0].data[0] = 32'hDEAD_BEEF;
      vecs[1] = mk(0, 32'h1234_0002, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1);
      vecs[2] = mk(0, 32'hC0F6_0002, 2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 2);
      vecs[3] = mk(0, 32'hC0F6_0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 3);
      vecs[4] = mk(1, 32'hC0F6_0003, 3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3, 4);
      vecs[5] = mk(1, 32'hC0F6_0002, 2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 5);
      vecs[6] = mk(0, 32'hC0F6_0003, 3, 1'b1, 1'b1, 1'b1, 1'b0, 16'd3, 6);
      vecs[7] = mk(0, 32'hC0F6_0002, 2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 7);

      // Reset and reset values.
      rst = 1'b1;
      #3 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("reset_flags_inst%0d", i),
               {bs_ready[i], config_we[i], busy[i], done[i], error[i]}, 64'd0);
         check($sformatf("reset_bus_inst%0d", i), {config_addr[i], config_data[i]}, 64'd0);
         check($sformatf("reset_writes_inst%0d", i), 64'(writes_done[i]), 64'd0);
      end
      rst = 1'b1;

      // Table-driven loads (vector 7 is kept for after the reset sequence).
      for (int n = 0; n < NV - 1; n++) run_load(vecs[n], $sformatf("vec%0d", n));

      // Reset during the DATA phase of write 2 of 4 on inst 0.
      v = mk(0, 32'hC0F6_0004, 4, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 9);
      last_strobe[0] = -1;
      push_exp(0, {v.addr[0], v.data[0]});
      pulse_start(0);
      send_word(0, v.hdr, 1'b0, hs_tmp);
      send_word(0, v.addr[0], 1'b0, hs_tmp);
      send_word(0, v.data[0], 1'b0, hs_tmp);
      send_word(0, v.addr[1], 1'b0, hs_tmp);
      @(negedge clk);
      bs_valid[0] = 1'b0;
      check("midload_in_data_state", 64'(fsm_state[0]), 64'(S_DATA));
      check("midload_writes_before_reset", 64'(writes_done[0]), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("midload_reset_flags",
            {bs_ready[0], config_we[0], busy[0], done[0], error[0]}, 64'd0);
      check("midload_reset_bus", {config_addr[0], config_data[0]}, 64'd0);
      check("midload_reset_writes", 64'(writes_done[0]), 64'd0);
      check("midload_queue_drained", 64'(exp_size(0)), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // A fresh load after the reset behaves normally.
      run_load(vecs[NV - 1], "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_config_loader

// File: doc/config_loader.md
# config_loader

Bitstream-driven configuration master for the tile array. Accepts a header-prefixed stream of (address, data) word pairs from the host over a valid/ready interface. Replays each pair onto the shared `config_addr`/`config_data` bus with a one-cycle write strobe. Every tile's address matchers decode that bus, so this block sits at the array root as the single source of all configuration writes.

## Interface

**Parameters**
- `MAGIC`, default 16'hC0F6: required value of header bits [31:16].
- `GAP`, default 0: idle cycles inserted after each write strobe, range 0–15.

**Ports** (`reset` is asynchronous and active-low)
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a load; honoured only when `busy`=0.
- `bs_data` input 32: bitstream word.
- `bs_valid` input 1: `bs_data` is valid.
- `bs_ready` output 1: loader accepts `bs_data` this cycle.
- `config_addr` output 32: {8'b0, config_id[7:0], tile_id[15:0]}, passed through verbatim.
- `config_data` output 32: write payload.
- `config_we` output 1: one-cycle write strobe; the bus is meaningful only while it is high.
- `busy` output 1: a load is in progress.
- `done` output 1: level; last load completed cleanly.
- `error` output 1: level; last load aborted on a bad header.
- `writes_done` output 16: count of strobes issued in the current or last load.

## Operation

- States: IDLE, HDR, ADDR, DATA, ISSUE, WAIT, DONE, ERR.
- **IDLE / DONE / ERR**
  - `bs_ready`=0.
  - On `start`: clear `done`, `error` and `writes_done`; go to HDR.
- **HDR**
  - `bs_ready`=1.
  - On handshake, if word[31:16]≠MAGIC, go to ERR.
  - Otherwise latch count N=word[15:0]. If N=0 go to DONE, else go to ADDR.
- **ADDR**
  - `bs_ready`=1.
  - On handshake, register `config_addr`; go to DATA.
- **DATA**
  - `bs_ready`=1.
  - On handshake, register `config_data`; go to ISSUE.
- **ISSUE**
  - `config_we`=1 for exactly one cycle; increment `writes_done`.
  - If `writes_done`+1==N: go to DONE when GAP=0, else to WAIT with the remaining-count flagged as zero.
  - Otherwise go to WAIT when GAP>0, else to ADDR.
- **WAIT**
  - Count GAP cycles, then go to ADDR, or to DONE if this was the final write.
- **Flags**
  - `busy`=1 in HDR, ADDR, DATA, ISSUE and WAIT.
  - `done`=1 in DONE; `error`=1 in ERR.
- `config_addr` and `config_data` hold their last values between strobes and after completion.
- The count is unsigned 16-bit; `writes_done` never exceeds N and never wraps, since N≤65535.
- A `bs_valid` with `bs_ready`=0 is ignored and the word is not consumed.
- A `start` while `busy` is ignored. A `start` coincident with the final ISSUE is also ignored.
- Bubbles on `bs_valid` stall the FSM in its current receive state indefinitely. There is no timeout.

## Timing

- Reset values:
  - `bs_ready`, `config_we`, `busy`, `done`, `error` = 0.
  - `config_addr`, `config_data` = 0.
  - `writes_done` = 0.
  - State = IDLE.
- Reset asserted mid-load returns all outputs to these values immediately (asynchronously). A strobe in flight is dropped.
- Start latency: `start` at cycle t puts the FSM in HDR with `bs_ready`=1 at t+1.
- Write latency: data handshake at cycle t gives `config_we`=1 at t+1, with `config_addr`/`config_data` already stable that cycle.
- Throughput with continuous `bs_valid`: one write per 3+GAP cycles.
- Completion: `done` rises the cycle after the final ISSUE (GAP=0), or the cycle after WAIT expires (GAP>0).
- `bs_ready` is a registered decode of state. It does not depend combinationally on `bs_valid`.

## Structure

- Shared package `config_pkg` holds:
  - the state enum;
  - the default `MAGIC` constant;
  - field positions for tile_id [15:0] and config_id [23:16], which the address matchers also use.
- No sub-module is needed. The FSM, the count/GAP counters and the bus registers are one flat module.

## Test plan

- **Single write:** reset, `start`, stream 32'hC0F6_0001, 32'h0001_0003, 32'hDEAD_BEEF with `bs_valid` held high.
  - One `config_we` pulse with addr=32'h0001_0003 and data=32'hDEADBEEF.
  - Then `done`=1 and `writes_done`=1.
- **Bad magic:** header 32'h1234_0002.
  - `error`=1, `bs_ready`=0 and no `config_we`.
  - A subsequent `start` with a valid stream clears `error` and completes.
- **Empty load:** header 32'hC0F6_0000.
  - `done` the cycle after the header handshake and `writes_done`=0.
- **Back-pressure and gaps:** N=3 with `bs_valid` toggling every cycle and GAP=2.
  - Exactly 3 strobes, each with its correct pair.
  - ≥2 idle cycles between strobes.
- **Reset mid-load:** assert `reset` low during DATA of write 2 of 4.
  - All outputs read 0 in that same cycle.
  - A fresh load then behaves normally.
- **Start while busy:** pulse `start` during ADDR.
  - Ignored; counts unchanged and the load finishes with `writes_done`=N.
